seq_restoring_divider: RTL and testbench

//  Multi-cycle shift/subtract divider, the inverse of the add/shift multiplier datapath.

---
 rtl/div_pkg.sv | 8 +
 rtl/div_sub_stage.sv | 34 +++
 rtl/seq_restoring_divider.sv | 130 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and defaults for the sequential restoring divider
package div_pkg;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_t;

  localparam int DIV_DEFAULT_W = 8;

endpackage

// File: rtl/div_sub_stage.sv
// rtl/div_sub_stage.sv - one restoring step: shift in the next dividend bit, trial subtract, restore
module div_sub_stage
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_W
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] a;
  logic [WIDTH:0] b;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] borrow;

  always_comb begin
    a         = {r, q_msb};
    b         = {1'b0, d};
    diff      = '0;
    borrow    = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      diff[i] = a[i] ^ b[i] ^ borrow[i];
      if (i < WIDTH)
        borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end
    // Partial remainder always stays below D, so W bits hold it after the step.
    q_bit  = ~diff[WIDTH];
    r_next = diff[WIDTH] ? a[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle signed/unsigned restoring divider with Run/Done handshake
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Signed_Op,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div_Zero,
  output logic             Overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic             sop;
  logic             dvd_neg;
  logic             dvs_neg;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;
  logic             sign;
  logic             ovf;

  // Magnitude of -2^(W-1) wraps to 2^(W-1), which is exact as a W-bit unsigned value.
  always_comb begin
    dvd_mag = (Signed_Op && Dividend[WIDTH-1]) ? -Dividend : Dividend;
    dvs_mag = (Signed_Op && Divisor[WIDTH-1])  ? -Divisor  : Divisor;
    sign    = sop & (dvd_neg ^ dvs_neg);
    ovf     = sop & ~sign & q_reg[WIDTH-1];
  end

  div_sub_stage #(.WIDTH(WIDTH)) u_stage (
    .r      (r_reg),
    .q_msb  (q_reg[WIDTH-1]),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= '0;
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      sop       <= 1'b0;
      dvd_neg   <= 1'b0;
      dvs_neg   <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Div_Zero  <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            sop     <= Signed_Op;
            dvd_neg <= Dividend[WIDTH-1];
            dvs_neg <= Divisor[WIDTH-1];
            d_reg   <= dvs_mag;
            q_reg   <= dvd_mag;
            r_reg   <= '0;
            count   <= '0;
            if (Divisor == '0) begin
              state     <= DONE;
              Done      <= 1'b1;
              Quotient  <= '1;
              Remainder <= Dividend;
              Div_Zero  <= 1'b1;
              Overflow  <= 1'b0;
            end else begin
              state <= ITER;
              Busy  <= 1'b1;
            end
          end
        end
        ITER: begin
          r_reg <= r_next;
          q_reg <= {q_reg[WIDTH-2:0], q_bit};
          if (count == LAST)
            state <= FIX;
          else
            count <= count + 1'b1;
        end
        FIX: begin
          if (ovf) begin
            Quotient  <= {1'b1, {(WIDTH-1){1'b0}}};
            Remainder <= '0;
          end else begin
            Quotient  <= sign ? -q_reg : q_reg;
            Remainder <= (sop && dvd_neg) ? -r_reg : r_reg;
          end
          Overflow <= ovf;
          Div_Zero <= 1'b0;
          Busy     <= 1'b0;
          Done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          // Held Run keeps us here so one button press yields exactly one divide.
          if (!Run) begin
            Done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - randomized self-checking bench against an arithmetic reference
module tb_seq_restoring_divider;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic       Signed_Op = 1'b0;
  logic [7:0] Dividend = '0;
  logic [7:0] Divisor = '0;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       Div_Zero;
  logic       Overflow;

  int n_tests = 0;
  int n_fail  = 0;

  seq_restoring_divider #(.WIDTH(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run       (Run),
    .Signed_Op (Signed_Op),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .Div_Zero  (Div_Zero),
    .Overflow  (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input bit s, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output bit dz, output bit ov);
    int sa;
    int sb;
    dz = 0;
    ov = 0;
    if (b == 8'h00) begin
      q  = 8'hFF;
      r  = a;
      dz = 1;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) begin
        q  = 8'h80;
        r  = 8'h00;
        ov = 1;
      end else begin
        q = 8'(sa / sb);
        r = 8'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic do_op(input bit s, input logic [7:0] a, input logic [7:0] b,
                       input bit scramble, input int hold, input string tag);
    logic [7:0] eq;
    logic [7:0] er;
    bit         edz;
    bit         eov;
    int         cyc;
    bit         seen;
    model(s, a, b, eq, er, edz, eov);
    @(negedge Clk);
    Signed_Op = s;
    Dividend  = a;
    Divisor   = b;
    Run       = 1'b1;
    @(posedge Clk);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge Clk);
      cyc++;
      #1;
      if (scramble && cyc == 3) begin
        Dividend  = 8'($urandom);
        Divisor   = 8'($urandom);
        Signed_Op = ~s;
      end
      if (Done) seen = 1;
    end
    check({tag, " done"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(cyc), (b == 8'h00) ? 32'd1 : 32'd9);
    check({tag, " quotient"}, 32'(Quotient), 32'(eq));
    check({tag, " remainder"}, 32'(Remainder), 32'(er));
    check({tag, " div_zero"}, 32'(Div_Zero), 32'(edz));
    check({tag, " overflow"}, 32'(Overflow), 32'(eov));
    check({tag, " busy"}, 32'(Busy), 32'd0);
    if (hold > 0) begin
      repeat (hold) @(posedge Clk);
      #1;
      check({tag, " held done"}, 32'(Done), 32'd1);
      check({tag, " held busy"}, 32'(Busy), 32'd0);
      check({tag, " held quotient"}, 32'(Quotient), 32'(eq));
    end
    @(negedge Clk);
    Run = 1'b0;
    @(posedge Clk);
    #1;
    check({tag, " release"}, 32'(Done), 32'd0);
    check({tag, " kept quotient"}, 32'(Quotient), 32'(eq));
  endtask

  initial begin
    #12;
    check("reset quotient", 32'(Quotient), 32'd0);
    check("reset remainder", 32'(Remainder), 32'd0);
    check("reset flags", {28'd0, Busy, Done, Div_Zero, Overflow}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    do_op(0, 8'd100, 8'd7, 0, 0, "u100/7");
    do_op(1, 8'hF9, 8'h02, 0, 0, "s-7/2");
    do_op(1, 8'h07, 8'hFE, 0, 0, "s7/-2");
    do_op(0, 8'h55, 8'h00, 0, 0, "zero div");
    do_op(1, 8'h80, 8'hFF, 0, 0, "s ovf");
    do_op(0, 8'h80, 8'hFF, 0, 0, "u 80/ff");
    do_op(1, 8'h80, 8'h01, 0, 0, "s -128/1");
    do_op(0, 8'hFF, 8'h01, 0, 0, "u ff/1");

    // Abort an operation in flight with an asynchronous reset.
    @(negedge Clk);
    Signed_Op = 1'b0;
    Dividend  = 8'd100;
    Divisor   = 8'd7;
    Run       = 1'b1;
    @(posedge Clk);
    repeat (4) @(posedge Clk);
    #1;
    check("mid-op busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("async quotient", 32'(Quotient), 32'd0);
    check("async remainder", 32'(Remainder), 32'd0);
    check("async flags", {28'd0, Busy, Done, Div_Zero, Overflow}, 32'd0);
    Run = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    do_op(0, 8'd200, 8'd10, 0, 0, "after reset");

    do_op(0, 8'd123, 8'd11, 0, 20, "run held");
    do_op(1, 8'hC3, 8'h05, 1, 0, "scrambled");

    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      bit         s;
      a = 8'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      s = 1'($urandom);
      do_op(s, a, b, 1'($urandom_range(0, 3) == 0), 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
